// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input handshake plus instruction-memory write
// port and boot status, bundled between the host link and the loader.
// master: the side feeding bytes and observing the loader.
// slave:  the loader itself.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] words;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  cpu_rst,
        input  done,
        input  err,
        input  words
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output cpu_rst,
        output done,
        output err,
        output words
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Parses frames of the form SYNC, LEN_LO, LEN_HI, 4*N data bytes (LSB first
// per word), assembles 32-bit words and writes them to consecutive word
// addresses starting at BASE_ADDR. The CPU is held in reset (cpu_rst low)
// until a full image has been written.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- when defined, a CSUM
// byte follows the data and must equal the XOR of all data bytes.
// All outputs are registered; nothing combinational reaches an output from
// in_data.
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [7:0]  SYNC      = 8'hA5
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    // State entered once the last data word has been written (or N = 0).
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t LOAD_END = CSUM;
`else
    localparam state_t LOAD_END = DONE;
`endif

    // DEPTH widened by one bit so N = 65535 and DEPTH compare without wrap.
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    state_t      state_reg,    state_next;
    logic [7:0]  len_lo_reg,   len_lo_next;
    logic [15:0] len_reg,      len_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [15:0] words_reg,    words_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg;
    logic [31:0] wdata_next;
    logic        mem_we_reg,   mem_we_next;
    logic        in_ready_reg, in_ready_next;
    logic        cpu_rst_reg,  cpu_rst_next;
    logic        done_reg,     done_next;
    logic        err_reg,      err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_reg,     csum_next;
`endif

    // Handshake decode; acceptance depends only on registered in_ready.
    logic        accept;
    logic        sync_seen;
    logic        data_accept;
    logic [15:0] len_full;
    logic [16:0] words_inc;
    logic [16:0] word_idx;
    logic [31:0] write_addr;

    assign accept      = bus.in_valid && in_ready_reg;
    assign sync_seen   = accept && (bus.in_data == SYNC);
    assign data_accept = accept && (state_reg == DATA);
    assign len_full    = {bus.in_data, len_lo_reg};
    assign words_inc   = {1'b0, words_reg} + 17'd1;

    // Clamp the word index so the write address can never pass the last
    // word of the memory, even if the count has saturated.
    assign word_idx   = ({1'b0, words_reg} >= DEPTH_W) ? (DEPTH_W - 17'd1)
                                                       : {1'b0, words_reg};
    assign write_addr = BASE_ADDR + {13'd0, word_idx, 2'b00};

    // Byte lanes: the byte counter selects which lane of the word under
    // assembly takes the incoming data byte; other lanes hold.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_next[8*gi +: 8] =
            (data_accept && (byte_cnt_reg == 2'(gi))) ? bus.in_data
                                                      : mem_wdata_reg[8*gi +: 8];
    end

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_next    = state_reg;
        len_lo_next   = len_lo_reg;
        len_next      = len_reg;
        byte_cnt_next = byte_cnt_reg;
        words_next    = words_reg;
        mem_addr_next = mem_addr_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_next     = csum_reg;
`endif

        case (state_reg)
            // Hunt for a frame start; anything else is dropped. DONE and
            // ERR share this: only SYNC starts a new load from them.
            IDLE, DONE, ERR: begin
                if (sync_seen) begin
                    state_next = LEN0;
                    words_next = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next  = '0;
`endif
                end
            end

            LEN0: begin
                if (accept) begin
                    len_lo_next = bus.in_data;
                    state_next  = LEN1;
                end
            end

            LEN1: begin
                if (accept) begin
                    len_next      = len_full;
                    byte_cnt_next = '0;
                    if ({1'b0, len_full} > DEPTH_W) begin
                        state_next = ERR;
                    end else if (len_full == 16'd0) begin
                        state_next = LOAD_END;
                    end else begin
                        state_next = DATA;
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_next     = csum_reg ^ bus.in_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        state_next    = WRITE;
                        mem_addr_next = write_addr;
                    end
                end
            end

            // One-cycle write strobe; the count advances as it ends.
            WRITE: begin
                if ({1'b0, words_reg} < DEPTH_W) begin
                    words_next = words_inc[15:0];
                end
                if (words_inc < {1'b0, len_reg}) begin
                    state_next = DATA;
                end else begin
                    state_next = LOAD_END;
                end
            end

`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_next = (bus.in_data == csum_reg) ? DONE : ERR;
                end
            end
`endif

            default: begin
                state_next = IDLE;
            end
        endcase

        // Registered outputs follow the state being entered, so each one is
        // valid for exactly the cycle that state occupies.
        mem_we_next   = (state_next == WRITE);
        in_ready_next = (state_next != WRITE);
        cpu_rst_next  = (state_next == DONE);
        done_next     = (state_next == DONE);
        err_next      = (state_next == ERR);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            len_lo_reg    <= '0;
            len_reg       <= '0;
            byte_cnt_reg  <= '0;
            words_reg     <= '0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            in_ready_reg  <= 1'b0;
            cpu_rst_reg   <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg      <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            len_lo_reg    <= len_lo_next;
            len_reg       <= len_next;
            byte_cnt_reg  <= byte_cnt_next;
            words_reg     <= words_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= wdata_next;
            mem_we_reg    <= mem_we_next;
            in_ready_reg  <= in_ready_next;
            cpu_rst_reg   <= cpu_rst_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg      <= csum_next;
`endif
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.cpu_rst   = cpu_rst_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.words     = words_reg;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames into imem_loader (DEPTH = 4) with a
// byte-level frame model checked against the DUT every cycle, plus literal
// expectations on the captured memory image and status outputs.
module tb_imem_loader;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [7:0]  SYNC  = 8'hA5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    localparam int P_HUNT = 0;
    localparam int P_LLO  = 1;
    localparam int P_LHI  = 2;
    localparam int P_DATA = 3;
    localparam int P_CSUM = 4;
    localparam int P_DONE = 5;
    localparam int P_ERR  = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    imem_loader_if bus ();

    imem_loader #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .SYNC      (SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory behind the write port: captures on the edge ending mem_we.
    logic [31:0] imem [0:DEPTH-1];
    logic [31:0] last_addr = '0;
    int          wr_count  = 0;

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) begin
            int idx;
            idx = int'((bus.mem_addr - BASE) >> 2);
            if (idx >= 0 && idx < DEPTH) imem[idx] <= bus.mem_wdata;
            last_addr <= bus.mem_addr;
            wr_count  <= wr_count + 1;
        end
    end

    // Frame model: what every output must be in the current cycle.
    bit          m_known  = 1'b0;
    bit          m_rstv   = 1'b0;
    int          m_phase  = P_HUNT;
    int          m_n      = 0;
    int          m_nb     = 0;
    int          m_words  = 0;
    bit          m_we     = 1'b0;
    bit          m_ready  = 1'b0;
    logic [7:0]  m_xor    = '0;
    logic [31:0] m_word   = '0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_data   = '0;

    // Compare this cycle, then advance the model across the next edge.
    always @(negedge clk) begin
        logic [7:0] b;
        if (m_known) begin
            chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
            chk("mem_we",   {31'd0, bus.mem_we},   {31'd0, m_we});
            chk("done",     {31'd0, bus.done},     {31'd0, m_phase == P_DONE});
            chk("cpu_rst",  {31'd0, bus.cpu_rst},  {31'd0, m_phase == P_DONE});
            chk("err",      {31'd0, bus.err},      {31'd0, m_phase == P_ERR});
            chk("words",    {16'd0, bus.words},    32'(m_words));
            if (m_we || m_rstv) begin
                chk("mem_addr",  bus.mem_addr,  m_addr);
                chk("mem_wdata", bus.mem_wdata, m_data);
            end
        end
        if (!rst) begin
            m_known = 1'b1;
            m_rstv  = 1'b1;
            m_phase = P_HUNT;
            m_words = 0;
            m_we    = 1'b0;
            m_ready = 1'b0;
            m_addr  = BASE;
            m_data  = '0;
        end else if (m_known) begin
            m_rstv = 1'b0;
            if (m_we) begin
                m_we = 1'b0;
                if (m_words < DEPTH) m_words++;
                if (m_words == m_n) m_phase = CK_EN ? P_CSUM : P_DONE;
            end else if (bus.in_valid && m_ready) begin
                b = bus.in_data;
                case (m_phase)
                    P_LLO: begin
                        m_n     = int'(b);
                        m_phase = P_LHI;
                    end
                    P_LHI: begin
                        m_n  = m_n + 256 * int'(b);
                        m_nb = 0;
                        if (m_n > DEPTH)   m_phase = P_ERR;
                        else if (m_n == 0) m_phase = CK_EN ? P_CSUM : P_DONE;
                        else               m_phase = P_DATA;
                    end
                    P_DATA: begin
                        m_word[8*(m_nb%4) +: 8] = b;
                        m_xor = m_xor ^ b;
                        m_nb++;
                        if (m_nb % 4 == 0) begin
                            m_we   = 1'b1;
                            m_addr = BASE + 32'(4 * m_words);
                            m_data = m_word;
                        end
                    end
                    P_CSUM: m_phase = (b == m_xor) ? P_DONE : P_ERR;
                    default: begin
                        if (b == SYNC) begin
                            m_phase = P_LLO;
                            m_words = 0;
                            m_xor   = '0;
                        end
                    end
                endcase
            end
            m_ready = !m_we;
        end
    end

    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit taken;
        taken = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 20 && !taken; k++) begin
            @(negedge clk);
            taken = (bus.in_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("FAIL byte_accept actual timeout required accepted byte %h", b);
        end
    endtask

    logic [7:0] fr [$];

    task automatic send_frame();
        foreach (fr[i]) send_byte(fr[i]);
    endtask

    int wr_base;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < DEPTH; i++) imem[i] = '0;
        #1;
        idle(3);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, BASE);
        rst = 1'b1;

        // Two-word frame; checksum 0x90 = 13^00^00^00^93^00^10^00.
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
        if (CK_EN) fr.push_back(8'h90);
        send_frame();
        idle(2);
        $display("frame A: writes %0d words %0d done %0b", wr_count, bus.words, bus.done);
        chk("A_wr_count", 32'(wr_count), 32'd2);
        chk("A_word0", imem[0], 32'h0000_0013);
        chk("A_word1", imem[1], 32'h0010_0093);
        chk("A_last_addr", last_addr, BASE + 32'h4);
        chk("A_done", {31'd0, bus.done}, 32'd1);
        chk("A_cpu_rst", {31'd0, bus.cpu_rst}, 32'd1);
        chk("A_words", {16'd0, bus.words}, 32'd2);

        // Garbage is dropped; then a one-word frame (checksum 0x08).
        wr_base = wr_count;
        fr = {8'h00, 8'hFF, 8'h5A};
        send_frame();
        idle(2);
        $display("garbage: writes %0d", wr_count);
        chk("G_no_write", 32'(wr_count), 32'(wr_base));
        fr = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        if (CK_EN) fr.push_back(8'h08);
        send_frame();
        idle(2);
        $display("frame B: writes %0d word0 %h", wr_count, imem[0]);
        chk("B_wr_count", 32'(wr_count), 32'(wr_base + 1));
        chk("B_word0", imem[0], 32'h1234_5678);

        // N = 5 exceeds DEPTH = 4: rejected with no writes.
        wr_base = wr_count;
        fr = {8'hA5, 8'h05, 8'h00};
        send_frame();
        idle(2);
        $display("oversize: err %0b cpu_rst %0b writes %0d", bus.err, bus.cpu_rst, wr_count);
        chk("E_err", {31'd0, bus.err}, 32'd1);
        chk("E_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
        chk("E_no_write", 32'(wr_count), 32'(wr_base));
        // Recovery frame (checksum 0x22).
        fr = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        if (CK_EN) fr.push_back(8'h22);
        send_frame();
        idle(2);
        $display("frame C: err %0b done %0b word0 %h", bus.err, bus.done, imem[0]);
        chk("C_err", {31'd0, bus.err}, 32'd0);
        chk("C_done", {31'd0, bus.done}, 32'd1);
        chk("C_word0", imem[0], 32'hDEAD_BEEF);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Correct checksum would be 0x04; 0x05 must be rejected after the write.
        wr_base = wr_count;
        fr = {8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame();
        idle(2);
        $display("bad csum: err %0b done %0b writes %0d", bus.err, bus.done, wr_count);
        chk("K_wr_count", 32'(wr_count), 32'(wr_base + 1));
        chk("K_word0", imem[0], 32'h0403_0201);
        chk("K_err", {31'd0, bus.err}, 32'd1);
        chk("K_done", {31'd0, bus.done}, 32'd0);
        chk("K_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
`endif

        // N = DEPTH: full memory, bytes 00..0F (checksum 0x00).
        wr_base = wr_count;
        fr = {8'hA5, 8'h04, 8'h00};
        for (int i = 0; i < 16; i++) fr.push_back(8'(i));
        if (CK_EN) fr.push_back(8'h00);
        send_frame();
        idle(2);
        $display("full: writes %0d words %0d last_addr %h", wr_count, bus.words, last_addr);
        chk("F_wr_count", 32'(wr_count), 32'(wr_base + 4));
        chk("F_word3", imem[3], 32'h0F0E_0D0C);
        chk("F_last_addr", last_addr, BASE + 32'hC);
        chk("F_words", {16'd0, bus.words}, 32'd4);

        // Gapped bytes then reset after 2 of 4 data bytes: no partial write.
        wr_base = wr_count;
        fr = {8'hA5, 8'h02, 8'h00};
        send_frame();
        idle(1);
        send_byte(8'h11);
        idle(1);
        send_byte(8'h22);
        idle(1);
        rst = 1'b0;
        idle(2);
        $display("mid-frame reset: writes %0d in_ready %0b", wr_count, bus.in_ready);
        chk("R_no_write", 32'(wr_count), 32'(wr_base));
        chk("R_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("R_words", {16'd0, bus.words}, 32'd0);
        chk("R_mem_wdata", bus.mem_wdata, 32'd0);
        rst = 1'b1;
        // Checksum 0x00 = AA^BB^CC^DD.
        fr = {8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        if (CK_EN) fr.push_back(8'h00);
        send_frame();
        idle(2);
        $display("frame D: last_addr %h word0 %h", last_addr, imem[0]);
        chk("D_last_addr", last_addr, BASE);
        chk("D_word0", imem[0], 32'hDDCC_BBAA);

        // Empty image, then a SYNC in DONE drops cpu_rst.
        wr_base = wr_count;
        fr = {8'hA5, 8'h00, 8'h00};
        if (CK_EN) fr.push_back(8'h00);
        send_frame();
        idle(2);
        $display("empty: done %0b words %0d writes %0d", bus.done, bus.words, wr_count);
        chk("Z_done", {31'd0, bus.done}, 32'd1);
        chk("Z_words", {16'd0, bus.words}, 32'd0);
        chk("Z_no_write", 32'(wr_count), 32'(wr_base));
        send_byte(SYNC);
        $display("restart: cpu_rst %0b done %0b", bus.cpu_rst, bus.done);
        chk("S_cpu_rst", {31'd0, bus.cpu_rst}, 32'd0);
        chk("S_done", {31'd0, bus.done}, 32'd0);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
